// File: rtl/window_3x3_gen_if.sv
// Pixel-stream in / 3x3 window out bundle for window_3x3_gen.
// The master drives pixels and observes windows; the generator is the slave.
interface window_3x3_gen_if #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int DATA_W     = 8
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [DATA_W-1:0] pixel_in;
    logic              pixel_valid;
    logic              sof;
    logic [DATA_W-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic              window_valid;
    logic [COL_W-1:0]  center_col;
    logic [ROW_W-1:0]  center_row;
    logic              frame_done;

    modport master (
        output pixel_in, pixel_valid, sof,
        input  p1, p2, p3, p4, p5, p6, p7, p8, p9,
        input  window_valid, center_col, center_row, frame_done
    );

    modport slave (
        input  pixel_in, pixel_valid, sof,
        output p1, p2, p3, p4, p5, p6, p7, p8, p9,
        output window_valid, center_col, center_row, frame_done
    );
endinterface

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift
// window, emitting only interior windows one clock after the newest pixel.
module window_3x3_gen #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int DATA_W     = 8
) (
    input logic            clk,
    input logic            rst_n,
    window_3x3_gen_if.slave bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] MIN_COL  = COL_W'(2);
    localparam logic [ROW_W-1:0] MIN_ROW  = ROW_W'(2);

    logic [COL_W-1:0]  colCnt, curCol, centerCol;
    logic [ROW_W-1:0]  rowCnt, curRow, centerRow;
    logic [DATA_W-1:0] lineBuf0 [IMG_WIDTH];
    logic [DATA_W-1:0] lineBuf1 [IMG_WIDTH];
    logic [DATA_W-1:0] win [9];
    logic              windowValid, frameDone;

    // sof relabels the current pixel as (0,0) whatever the counters say.
    always_comb begin
        curCol = colCnt;
        curRow = rowCnt;
        if (bus.sof) begin
            curCol = '0;
            curRow = '0;
        end
    end

    // NOTE: line buffers carry no reset so they map onto RAM; stale contents are masked by the row>=2 gate.
    always_ff @(posedge clk) begin
        if (bus.pixel_valid) begin
            lineBuf1[curCol] <= lineBuf0[curCol];
            lineBuf0[curCol] <= bus.pixel_in;
        end
    end

    // NOTE: non-blocking assignments let every window tap shift from its pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colCnt      <= '0;
            rowCnt      <= '0;
            centerCol   <= '0;
            centerRow   <= '0;
            windowValid <= 1'b0;
            frameDone   <= 1'b0;
            for (int i = 0; i < 9; i++) win[i] <= '0;
        end else begin
            windowValid <= 1'b0;
            frameDone   <= 1'b0;
            if (bus.pixel_valid) begin
                for (int i = 0; i < 6; i++) win[i] <= win[i+3];
                win[6] <= lineBuf1[curCol];
                win[7] <= lineBuf0[curCol];
                win[8] <= bus.pixel_in;

                centerCol   <= curCol - COL_W'(1);
                centerRow   <= curRow - ROW_W'(1);
                windowValid <= (curRow >= MIN_ROW) && (curCol >= MIN_COL);
                frameDone   <= (curRow == LAST_ROW) && (curCol == LAST_COL);

                if (curCol == LAST_COL) begin
                    colCnt <= '0;
                    rowCnt <= (curRow == LAST_ROW) ? '0 : curRow + ROW_W'(1);
                end else begin
                    colCnt <= curCol + COL_W'(1);
                    rowCnt <= curRow;
                end
            end
        end
    end

    assign bus.p1           = win[0];
    assign bus.p2           = win[1];
    assign bus.p3           = win[2];
    assign bus.p4           = win[3];
    assign bus.p5           = win[4];
    assign bus.p6           = win[5];
    assign bus.p7           = win[6];
    assign bus.p8           = win[7];
    assign bus.p9           = win[8];
    assign bus.window_valid = windowValid;
    assign bus.center_col   = centerCol;
    assign bus.center_row   = centerRow;
    assign bus.frame_done   = frameDone;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench: a 4x4 instance for the scenario tests and a 256x3
// instance for random minimum-height frames, both against an image-array model.
module tb_window_3x3_gen;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    window_3x3_gen_if #(.IMG_WIDTH(4),   .IMG_HEIGHT(4), .DATA_W(8)) ifA ();
    window_3x3_gen_if #(.IMG_WIDTH(256), .IMG_HEIGHT(3), .DATA_W(8)) ifB ();

    window_3x3_gen #(.IMG_WIDTH(4),   .IMG_HEIGHT(4), .DATA_W(8))
        dutA (.clk(clk), .rst_n(rst_n), .bus(ifA.slave));
    window_3x3_gen #(.IMG_WIDTH(256), .IMG_HEIGHT(3), .DATA_W(8))
        dutB (.clk(clk), .rst_n(rst_n), .bus(ifB.slave));

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: each instance's image kept as rows (mod 4) of pixels.
    int mdl [2][4][256];
    int mRow[2], mCol[2];
    int winCnt[2], doneCnt[2];

    function automatic int imgW(input bit sel);
        return sel ? 256 : 4;
    endfunction

    function automatic int imgH(input bit sel);
        return sel ? 3 : 4;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mRow[s] = 0;
            mCol[s] = 0;
        end
    endtask

    // One clock: present a pixel (or idle), then check the registered result.
    task automatic step(input bit sel, input bit v, input bit s, input int pix, input string tag);
        int r, c, exp[9], act[9];
        bit expValid, expDone, actValid, actDone, pBad;
        int actRow, actCol;
        if (sel) begin
            ifB.pixel_valid = v; ifB.sof = s; ifB.pixel_in = pix[7:0];
        end else begin
            ifA.pixel_valid = v; ifA.sof = s; ifA.pixel_in = pix[7:0];
        end
        @(posedge clk);
        #1;
        expValid = 1'b0;
        expDone  = 1'b0;
        r = 0;
        c = 0;
        if (v) begin
            if (s) begin
                mRow[sel] = 0;
                mCol[sel] = 0;
            end
            r = mRow[sel];
            c = mCol[sel];
            mdl[sel][r % 4][c] = pix & 8'hff;
            expValid = (r >= 2) && (c >= 2);
            expDone  = expValid && (r == imgH(sel) - 1) && (c == imgW(sel) - 1);
            if (expValid)
                for (int col = 0; col < 3; col++)
                    for (int row = 0; row < 3; row++)
                        exp[col*3 + row] = mdl[sel][(r - 2 + row) % 4][c - 2 + col];
            mCol[sel] = c + 1;
            if (mCol[sel] == imgW(sel)) begin
                mCol[sel] = 0;
                mRow[sel] = (r + 1 == imgH(sel)) ? 0 : r + 1;
            end
        end
        if (sel) begin
            act = '{ifB.p1, ifB.p2, ifB.p3, ifB.p4, ifB.p5, ifB.p6, ifB.p7, ifB.p8, ifB.p9};
            actValid = ifB.window_valid; actDone = ifB.frame_done;
            actRow = int'(ifB.center_row); actCol = int'(ifB.center_col);
        end else begin
            act = '{ifA.p1, ifA.p2, ifA.p3, ifA.p4, ifA.p5, ifA.p6, ifA.p7, ifA.p8, ifA.p9};
            actValid = ifA.window_valid; actDone = ifA.frame_done;
            actRow = int'(ifA.center_row); actCol = int'(ifA.center_col);
        end
        if (actValid) winCnt[sel]++;
        if (actDone)  doneCnt[sel]++;

        testsRun++;
        if (actValid !== expValid) begin
            testsFailed++;
            $display("FAIL %s window_valid v=%0b pos=(%0d,%0d): got %0b want %0b", tag, v, r, c, actValid, expValid);
        end
        testsRun++;
        if (actDone !== expDone) begin
            testsFailed++;
            $display("FAIL %s frame_done v=%0b pos=(%0d,%0d): got %0b want %0b", tag, v, r, c, actDone, expDone);
        end
        if (expValid) begin
            pBad = 1'b0;
            for (int k = 0; k < 9; k++) if (act[k] !== exp[k]) pBad = 1'b1;
            testsRun++;
            if (pBad) begin
                testsFailed++;
                $display("FAIL %s window pos=(%0d,%0d): got %p want %p", tag, r, c, act, exp);
            end
            testsRun++;
            if (actRow !== r - 1 || actCol !== c - 1) begin
                testsFailed++;
                $display("FAIL %s centre: got (%0d,%0d) want (%0d,%0d)", tag, actRow, actCol, r - 1, c - 1);
            end
        end
    endtask

    task automatic idle_inputs();
        ifA.pixel_valid = 1'b0; ifA.sof = 1'b0; ifA.pixel_in = '0;
        ifB.pixel_valid = 1'b0; ifB.sof = 1'b0; ifB.pixel_in = '0;
    endtask

    // gapMode 1: valid pattern 1,0,0 with garbage pixel/sof on idle cycles.
    task automatic stream(input bit sel, input int n, input bit rnd, input int base,
                          input bit useSof, input int gapMode, input string tag);
        for (int i = 0; i < n; i++) begin
            step(sel, 1'b1, useSof && (i == 0), rnd ? int'($urandom_range(0, 255)) : base + i, tag);
            if (gapMode == 1) begin
                step(sel, 1'b0, 1'b1, int'($urandom_range(0, 255)), tag);
                step(sel, 1'b0, 1'b0, int'($urandom_range(0, 255)), tag);
            end else if (gapMode == 2 && $urandom_range(0, 7) == 0) begin
                step(sel, 1'b0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)), tag);
            end
        end
    endtask

    task automatic check_count(input string tag, input int got, input int want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic check_zero_a(input string tag);
        testsRun++;
        if ({ifA.p1, ifA.p2, ifA.p3, ifA.p4, ifA.p5, ifA.p6, ifA.p7, ifA.p8, ifA.p9} !== '0 ||
            ifA.window_valid !== 1'b0 || ifA.frame_done !== 1'b0 ||
            ifA.center_col !== '0 || ifA.center_row !== '0) begin
            testsFailed++;
            $display("FAIL %s outputs not zero: p5=%0h valid=%0b done=%0b centre=(%0d,%0d) want all 0",
                     tag, ifA.p5, ifA.window_valid, ifA.frame_done, ifA.center_row, ifA.center_col);
        end
    endtask

    task automatic clear_counts();
        winCnt  = '{0, 0};
        doneCnt = '{0, 0};
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_n = 1'b0;
        #2 check_zero_a("reset");
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp();
        clear_counts();
        stream(1'b0, 16, 1'b0, 0, 1'b1, 0, "ramp");
        check_count("ramp windows", winCnt[0], 4);
        check_count("ramp frame_done", doneCnt[0], 1);
        check_count("ramp last p9", int'(ifA.p9), 15);
        check_count("ramp last centre", int'(ifA.center_row) * 16 + int'(ifA.center_col), 2 * 16 + 2);
        step(1'b0, 1'b0, 1'b0, 0, "ramp tail");
    endtask

    task automatic test_stall();
        clear_counts();
        stream(1'b0, 16, 1'b0, 0, 1'b1, 1, "stall");
        check_count("stall windows", winCnt[0], 4);
        check_count("stall frame_done", doneCnt[0], 1);
    endtask

    task automatic test_back_to_back();
        clear_counts();
        stream(1'b0, 16, 1'b0, 0, 1'b1, 0, "b2b f0");
        stream(1'b0, 16, 1'b0, 100, 1'b1, 0, "b2b f1");
        check_count("b2b windows", winCnt[0], 8);
        check_count("b2b frame_done", doneCnt[0], 2);
    endtask

    task automatic test_mid_sof();
        clear_counts();
        stream(1'b0, 9, 1'b0, 0, 1'b1, 0, "midsof partial");
        stream(1'b0, 16, 1'b0, 0, 1'b1, 0, "midsof frame");
        check_count("midsof windows", winCnt[0], 4);
        check_count("midsof frame_done", doneCnt[0], 1);
    endtask

    task automatic test_reset_mid();
        stream(1'b0, 11, 1'b0, 0, 1'b1, 0, "rstmid partial");
        idle_inputs();
        #2 rst_n = 1'b0;
        #1 check_zero_a("rstmid async");
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        clear_counts();
        stream(1'b0, 16, 1'b0, 0, 1'b0, 0, "rstmid frame");
        check_count("rstmid windows", winCnt[0], 4);
        check_count("rstmid frame_done", doneCnt[0], 1);
    endtask

    task automatic test_min_height();
        clear_counts();
        stream(1'b1, 768, 1'b1, 0, 1'b1, 2, "minh");
        check_count("minh windows", winCnt[1], 254);
        check_count("minh frame_done", doneCnt[1], 1);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_ramp();
        test_stall();
        test_back_to_back();
        test_mid_sof();
        test_reset_mid();
        test_min_height();
        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
Streaming 3x3 neighbourhood generator that sits directly upstream of the 3x3 median filter. It accepts one raster-order pixel per valid cycle and keeps the two previous image lines in internal line buffers. It presents the full 3x3 window on p1..p9 with a window_valid qualifier and the centre-pixel coordinates. Only interior centres are produced, so the output image is (IMG_WIDTH-2) x (IMG_HEIGHT-2).

Parameters:
IMG_WIDTH, 256, pixels per line (>=3); sets line-buffer depth and column counter range
IMG_HEIGHT, 256, lines per frame (>=3)
DATA_W, 8, pixel width; the median consumer requires 8

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
pixel_in  in  DATA_W  incoming pixel, raster order
pixel_valid  in  1  pixel_in is accepted this cycle
sof  in  1  start of frame; qualified by pixel_valid, marks pixel (0,0)
p1..p9  out  DATA_W each  window; p1,p2,p3 = left column top-to-bottom; p4,p5,p6 = middle column; p7,p8,p9 = right column (p1,p4,p7 = top row)
window_valid  out  1  p1..p9 hold a complete interior window
center_col  out  clog2(IMG_WIDTH)  column of the centre pixel (p5)
center_row  out  clog2(IMG_HEIGHT)  row of the centre pixel (p5)
frame_done  out  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Reset (async, rst_n=0): p1..p9=0, window_valid=0, frame_done=0, center_col/row=0, col/row counters=0. Line-buffer RAM is not cleared; its stale content is never flagged valid.
- Two line buffers of IMG_WIDTH x DATA_W: lb0 holds line r-1 and lb1 holds line r-2, both indexed by the column counter c.
- On an accepted pixel (pixel_valid=1) at (r,c), registered in one cycle:
  - p1,p2,p3 <= p4,p5,p6;
  - p4,p5,p6 <= p7,p8,p9;
  - p7 <= lb1[c]; p8 <= lb0[c]; p9 <= pixel_in;
  - lb1[c] <= lb0[c]; lb0[c] <= pixel_in (read-before-write at the same address).
- Counters: c increments per accepted pixel. At c=IMG_WIDTH-1, c wraps to 0 and r increments. At r=IMG_HEIGHT-1 and c=IMG_WIDTH-1, both wrap to 0.
- sof=1 with pixel_valid=1: that pixel is treated as (0,0) regardless of counter state. The counters then continue from (0,1). sof without pixel_valid is ignored.
- window_valid: 1 in the cycle after accepting pixel (r,c) with r>=2 and c>=2. In that cycle center_row=r-1 and center_col=c-1. Latency from pixel_in to window output is 1 clock.
- Windows at c=0 and c=1 hold pixels wrapped from the previous line's right edge. They are deasserted, not zeroed.
- pixel_valid=0: p1..p9, center_* and counters hold; window_valid=0 and frame_done=0 that cycle. Stalls of any length are lossless.
- frame_done=1 for exactly one cycle, together with the window for centre (IMG_HEIGHT-2, IMG_WIDTH-2).
- sof mid-frame: counters force to (0,0) on that pixel and the partial frame is abandoned without frame_done. Windows resume only once the new frame reaches r>=2, c>=2.
- Reset mid-frame: all outputs and counters return to 0 immediately. The next accepted pixel is (0,0), with or without sof.
- Back-to-back frames with no idle cycles are supported. Rows 0–1 of a new frame never produce windows, so the previous frame's data cannot leak.
- Downstream note: the median stage adds 3 clocks of latency and has no valid input. The integrator delays window_valid, center_* and frame_done by 3 registers; that delay is not part of this block.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, ramp pixels 0..15 with continuous valid and sof on pixel 0 -> exactly 4 windows. First: p1..p9=0,4,8,1,5,9,2,6,10, centre (1,1). Last: p9=15, centre (2,2), frame_done=1 in the same cycle only.
- Same ramp with pixel_valid toggling 1,0,0,1,... -> identical window sequence and centres. window_valid and frame_done never asserted on idle cycles.
- 4x4 frames back-to-back, second frame = 100..115 -> second frame's first window is p1..p9=100,104,108,101,105,109,102,106,110. No window_valid during the second frame's rows 0–1.
- sof asserted at pixel 9 of a frame, then 16 ramp pixels 0..15 -> no frame_done for the abandoned frame. The following 4 windows match scenario 1.
- rst_n pulsed low after pixel 10 of a frame -> outputs 0 asynchronously. A fresh 0..15 frame without sof yields the scenario 1 windows.
- IMG_WIDTH=256, IMG_HEIGHT=3 (minimum height), random pixels -> 254 windows, all centre_row=1. Each window matches a software 3x3 extraction.
